// File: rtl/qchannel_pkg.sv
// Shared definitions for the Q-Channel controller: FSM state encoding and the
// supported synchronizer depth range.
package qchannel_pkg;

  typedef enum logic [2:0] {
    Q_RUN     = 3'd0,
    Q_REQUEST = 3'd1,
    Q_STOPPED = 3'd2,
    Q_EXIT    = 3'd3,
    Q_DENIED  = 3'd4
  } q_state_e;

  localparam int Q_SYNC_STAGES_MIN = 0;
  localparam int Q_SYNC_STAGES_MAX = 3;

  // Out-of-range depths are pulled back into the supported range.
  function automatic int q_sync_clamp(int stages);
    if (stages < Q_SYNC_STAGES_MIN) return Q_SYNC_STAGES_MIN;
    if (stages > Q_SYNC_STAGES_MAX) return Q_SYNC_STAGES_MAX;
    return stages;
  endfunction

endpackage

// File: rtl/qchannel_sync.sv
// N-stage flop synchronizer with asynchronous active-low reset and a
// per-instance reset value; STAGES=0 is a direct connection.
module qchannel_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (STAGES == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk_i ^ rst_ni ^ RST_VAL;
    assign q_o = d_i;
  end else begin : g_flops
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
      sync_d = (sync_q << 1) | STAGES'(d_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= {STAGES{RST_VAL}};
      end else begin
        sync_q <= sync_d;
      end
    end

    assign q_o = sync_q[STAGES-1];
  end

endmodule

// File: rtl/qchannel_controller.sv
// Q-Channel initiator: requests device quiescence after a programmable idle
// period, handles accept/deny, and exits STOPPED on wake or disable.
module qchannel_controller
  import qchannel_pkg::*;
#(
  parameter int unsigned IDLE_CNT_W  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DENY_CNT_W  = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  en_i,
  input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
  input  logic                  activity_i,
  input  logic                  wake_req_i,
  output logic                  qreqn_o,
  input  logic                  qacceptn_i,
  input  logic                  qdeny_i,
  output logic                  stopped_o,
  output logic [DENY_CNT_W-1:0] deny_cnt_o,
  output logic                  proto_err_o
);

  localparam int unsigned SYNC_N = unsigned'(q_sync_clamp(int'(SYNC_STAGES)));

  logic acc;
  logic dny;

  qchannel_sync #(
    .STAGES  (SYNC_N),
    .RST_VAL (1'b0)
  ) u_sync_acc (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .d_i    (qacceptn_i),
    .q_o    (acc)
  );

  qchannel_sync #(
    .STAGES  (SYNC_N),
    .RST_VAL (1'b0)
  ) u_sync_dny (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .d_i    (qdeny_i),
    .q_o    (dny)
  );

  q_state_e              state_q, state_d;
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [DENY_CNT_W-1:0] deny_cnt_q, deny_cnt_d;
  logic                  wake_pend_q, wake_pend_d;
  logic                  proto_err_q, proto_err_d;
  logic                  qreqn_q, qreqn_d;
  logic                  stopped_q, stopped_d;

  logic                  idle_count_en;
  logic [IDLE_CNT_W:0]   idle_next;
  logic                  idle_hit;

  always_comb begin
    idle_count_en = !activity_i && !wake_req_i && en_i && (idle_thresh_i != '0);
    idle_next     = {1'b0, idle_cnt_q} + {{IDLE_CNT_W{1'b0}}, 1'b1};
    idle_hit      = (idle_next == {1'b0, idle_thresh_i});

    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    deny_cnt_d  = deny_cnt_q;
    wake_pend_d = wake_pend_q;
    proto_err_d = proto_err_q;

    unique case (state_q)
      Q_RUN: begin
        if (idle_count_en) begin
          idle_cnt_d = (idle_cnt_q == '1) ? idle_cnt_q : idle_next[IDLE_CNT_W-1:0];
          if (idle_hit) state_d = Q_REQUEST;
        end else begin
          idle_cnt_d = '0;
        end
      end
      Q_REQUEST: begin
        // qreqn must stay low until the device answers, so a wake is deferred.
        if (wake_req_i || !en_i) wake_pend_d = 1'b1;
        if (!acc) begin
          state_d = Q_STOPPED;
          if (dny) proto_err_d = 1'b1;
        end else if (dny) begin
          state_d = Q_DENIED;
          if (deny_cnt_q != '1) deny_cnt_d = deny_cnt_q + DENY_CNT_W'(1);
        end
      end
      Q_STOPPED: begin
        if (wake_req_i || !en_i || wake_pend_q) begin
          state_d     = Q_EXIT;
          wake_pend_d = 1'b0;
        end
      end
      Q_EXIT: begin
        if (dny) begin
          proto_err_d = 1'b1;
        end else if (acc) begin
          state_d    = Q_RUN;
          idle_cnt_d = '0;
        end
      end
      Q_DENIED: begin
        if (!acc) proto_err_d = 1'b1;
        if (!dny) begin
          state_d     = Q_RUN;
          idle_cnt_d  = '0;
          wake_pend_d = 1'b0;
        end
      end
      default: state_d = Q_STOPPED;
    endcase

    // Outputs are registered copies decoded from the next state.
    qreqn_d   = !((state_d == Q_REQUEST) || (state_d == Q_STOPPED));
    stopped_d = (state_d == Q_STOPPED);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= Q_STOPPED;
      idle_cnt_q  <= '0;
      deny_cnt_q  <= '0;
      wake_pend_q <= 1'b0;
      proto_err_q <= 1'b0;
      qreqn_q     <= 1'b0;
      stopped_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      deny_cnt_q  <= deny_cnt_d;
      wake_pend_q <= wake_pend_d;
      proto_err_q <= proto_err_d;
      qreqn_q     <= qreqn_d;
      stopped_q   <= stopped_d;
    end
  end

  assign qreqn_o     = qreqn_q;
  assign stopped_o   = stopped_q;
  assign deny_cnt_o  = deny_cnt_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: doc/qchannel_controller.md
# qchannel_controller

Controller (initiator) end of the Q-Channel low-power interface. It drives `qreqn` to a Q-Channel device such as the quiescable SPI wrapper and watches the device's `qacceptn` and `qdeny` responses. It requests quiescence after a programmable number of idle cycles, handles denial, and exits the stopped state on wake or disable. It sits in the power/clock controller and provides `stopped_o` as the clock-gate enable indication.

## Interface
- `IDLE_CNT_W`, 16: width of the idle counter and threshold.
- `SYNC_STAGES`, 2: synchronizer depth on `qacceptn_i`/`qdeny_i`; legal values 0 (same clock, direct) to 3.
- `DENY_CNT_W`, 8: width of the saturating deny counter.

Ports:
- `wb_clk_i`  in  1  single clock, all logic on rising edge.
- `wb_rst_ni`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  auto-quiesce enable; 0 forces exit and holds RUN.
- `idle_thresh_i`  in  IDLE_CNT_W  consecutive idle cycles before a request; 0 disables auto-request.
- `activity_i`  in  1  device/bus activity (e.g. `wb_cyc_i | wb_stb_i`).
- `wake_req_i`  in  1  level wake request.
- `qreqn_o`  out  1  Q-Channel request, active-low, registered.
- `qacceptn_i`  in  1  device accept, active-low.
- `qdeny_i`  in  1  device deny.
- `stopped_o`  out  1  high only in STOPPED.
- `deny_cnt_o`  out  DENY_CNT_W  saturating count of denials.
- `proto_err_o`  out  1  sticky protocol-violation flag.

## Operation
- States: RUN, REQUEST, STOPPED, EXIT, DENIED.
- `qreqn_o` is 0 in REQUEST and STOPPED, and 1 in RUN, EXIT and DENIED.
- `acc`/`dny` denote the synchronized `qacceptn_i`/`qdeny_i`.
- Reset state is STOPPED, which matches a device that resets stopped. Reset values: `qreqn_o`=0, `stopped_o`=1, `deny_cnt_o`=0, `proto_err_o`=0, idle counter 0, wake_pend 0. Synchronizer flops reset to `acc`=0 and `dny`=0.
- RUN:
  - The idle counter increments on each cycle where `activity_i`=0, `wake_req_i`=0, `en_i`=1 and `idle_thresh_i`≠0, saturating at all-ones.
  - Any other cycle clears the counter.
  - When counter+1 == `idle_thresh_i` on a counting cycle, go to REQUEST.
- REQUEST (`qreqn_o` must not rise until the device responds):
  - `acc`=0 → STOPPED.
  - `dny`=1 → DENIED, and `deny_cnt_o` increments (saturating).
  - `acc`=0 and `dny`=1 in the same cycle is illegal: go to STOPPED and set `proto_err_o`.
  - `wake_req_i` or `en_i`=0 arriving in REQUEST sets wake_pend.
- STOPPED:
  - `wake_req_i`=1, `en_i`=0 or wake_pend=1 → EXIT, and wake_pend clears.
- EXIT:
  - `acc`=1 → RUN, and the idle counter clears.
  - `dny`=1 in EXIT sets `proto_err_o`; the state is unchanged.
- DENIED:
  - `dny`=0 → RUN, and the counter clears. wake_pend clears here because the device is running.
  - `acc`=0 in DENIED sets `proto_err_o`.
- `proto_err_o` is cleared only by reset.

## Timing
- All outputs are registered. There is no combinational input-to-output path.
- `qreqn_o` falls on the edge ending the `idle_thresh_i`-th consecutive counting cycle in RUN.
- Response latency from a device output change to a state change is SYNC_STAGES+1 edges; with SYNC_STAGES=0 it is 1 edge.
- `stopped_o` rises in the same cycle the state becomes STOPPED and falls in the same cycle EXIT is entered. `qreqn_o` rises in that same cycle.
- Activity in the cycle the counter would reach the threshold wins: the counter clears and there is no request.
- An asynchronous reset mid-handshake returns to STOPPED immediately with `qreqn_o`=0, regardless of the device state.

## Structure
- Shared package `qchannel_pkg` holds:
  - the 3-bit state encoding constants Q_RUN, Q_REQUEST, Q_STOPPED, Q_EXIT, Q_DENIED;
  - the legal SYNC_STAGES range.
- Sub-module `qchannel_sync`: an N-stage (0–3) flop synchronizer with asynchronous active-low reset and a per-instance reset value. It is instantiated twice, once for `qacceptn_i` and once for `qdeny_i`.
- The FSM, idle counter, deny counter and error flag live in the top module.

## Test plan
- Reset → exit, with SYNC_STAGES=0:
  - Stimulus: release reset with `wake_req_i`=1 and the device model holding `qacceptn`=0, then raising it 1 cycle after `qreqn` rises.
  - Required: `qreqn_o`=0 in reset, `qreqn_o`=1 on the 1st edge, state RUN on the 3rd edge, `stopped_o`=0.
- Idle entry:
  - Stimulus: `idle_thresh_i`=5, `activity_i`=0, device accepts 3 cycles after the request.
  - Required: `qreqn_o` falls on the 5th idle edge, `stopped_o`=1 four edges later (3 cycles plus 1 edge of latency).
  - Variant: a pulse on `activity_i` at idle cycle 4 → no request; the count restarts from 0.
- Denial:
  - Stimulus: device asserts `qdeny` 2 cycles after `qreqn` falls, and drops it 2 cycles after `qreqn` rises.
  - Required: `deny_cnt_o`=1, `qreqn_o`=1 in DENIED, RUN afterwards.
  - Variant: 300 denials with DENY_CNT_W=8 → `deny_cnt_o`=255.
- Wake during REQUEST:
  - Stimulus: `wake_req_i` pulses for 1 cycle while in REQUEST; device accepts later.
  - Required: `qreqn_o` stays 0 until the accept, STOPPED lasts exactly 1 cycle, then EXIT.
- Protocol error:
  - Stimulus: `qacceptn`=0 and `qdeny`=1 simultaneously in REQUEST.
  - Required: STOPPED entered, `proto_err_o`=1, and it stays 1 until reset.
- SYNC_STAGES=2 and mid-handshake reset:
  - Required: accept latency is 3 edges.
  - Stimulus: assert `wb_rst_ni` low while in EXIT → `qreqn_o`=0 and `stopped_o`=1 asynchronously.
